// File: rtl/gth_link_ctl_pkg.sv
// gth_link_ctl_pkg: shared types for the SFP0 GTH link sequencer.
// State encoding, GTH status bit positions and the all-ready mask.
package gth_link_ctl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ASSERT_RST = 3'd1,
      ST_WAIT_PLL   = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_STABLE     = 3'd4,
      ST_LINKED     = 3'd5,
      ST_RETRY      = 3'd6,
      ST_FAULT      = 3'd7
   } gth_state_e;

   localparam int unsigned QPLL_LOCK = 0;
   localparam int unsigned TX_DONE   = 1;
   localparam int unsigned RX_DONE   = 2;
   localparam int unsigned CDR_LOCK  = 3;

   localparam logic [3:0] STS_ALL_READY = 4'b1111;

endpackage

// File: rtl/gth_sts_sync.sv
// gth_sts_sync: W-bit 2-flop synchronizer, clears to 0 on reset.
// Ports: clk_i, rst_i (sync, high), d_i async in, q_o synced out.
module gth_sts_sync #(
   parameter int unsigned W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/gth_link_ctl.sv
// gth_link_ctl: GTH bring-up / supervision sequencer (axi_clk domain).
// In: axi_clk, rst (sync high), enable, restart, gth_status[3:0].
// Out: gth_rst, link_up, fault, state[2:0], retry_cnt[3:0].
// GTH_LINK_CTL_STATS_EN adds drop_cnt[15:0], last_up_cycles[31:0].
module gth_link_ctl
   import gth_link_ctl_pkg::*;
#(
   parameter int unsigned RST_CYCLES     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 2500000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES    = 7
) (
   input  logic        axi_clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        restart,
   input  logic [3:0]  gth_status,
   output logic        gth_rst,
   output logic        link_up,
   output logic        fault,
   output logic [2:0]  state,
   output logic [3:0]  retry_cnt
`ifdef GTH_LINK_CTL_STATS_EN
   ,
   output logic [15:0] drop_cnt,
   output logic [31:0] last_up_cycles
`endif
);

   // One timer serves both the reset hold and the wait timeouts.
   localparam int unsigned TMR_MAX =
      (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
   localparam int unsigned TW = $clog2(TMR_MAX + 1);
   localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TMR_SAT   = TW'(TMR_MAX);
   localparam logic [SW-1:0] STB_LAST  = SW'(STABLE_CYCLES - 1);
   localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

   gth_state_e    state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [SW-1:0] stb_q, stb_d;
   logic [3:0]    retry_q, retry_d;
   logic          gth_rst_q, link_up_q, fault_q;
   logic [3:0]    sts;
   logic          tmr_clr, tmo, all_rdy, done3;

   gth_sts_sync #(.W(4)) u_sync (
      .clk_i (axi_clk),
      .rst_i (rst),
      .d_i   (gth_status),
      .q_o   (sts)
   );

   assign tmo     = (tmr_q == TMO_LAST);
   assign all_rdy = (sts == STS_ALL_READY);
   assign done3   = sts[QPLL_LOCK] & sts[TX_DONE] & sts[RX_DONE];

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      stb_d   = '0;
      tmr_clr = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         retry_d = '0;
      end else if (restart) begin
         // Restart re-enters ASSERT_RST even from ASSERT_RST itself.
         state_d = ST_ASSERT_RST;
         retry_d = '0;
         tmr_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_ASSERT_RST;
            ST_ASSERT_RST: begin
               if (tmr_q == RST_LAST) state_d = ST_WAIT_PLL;
            end
            ST_WAIT_PLL: begin
               if (sts[QPLL_LOCK]) state_d = ST_WAIT_DONE;
               else if (tmo)       state_d = ST_RETRY;
            end
            ST_WAIT_DONE: begin
               if (done3)                      state_d = ST_STABLE;
               else if (!sts[QPLL_LOCK] || tmo) state_d = ST_RETRY;
            end
            ST_STABLE: begin
               // Success is tested first so it wins over a timeout.
               if (all_rdy && stb_q == STB_LAST) begin
                  state_d = ST_LINKED;
                  retry_d = '0;
               end else if (tmo) begin
                  state_d = ST_RETRY;
               end else if (all_rdy) begin
                  stb_d = stb_q + SW'(1);
               end
            end
            ST_LINKED: begin
               if (!all_rdy) state_d = ST_RETRY;
            end
            ST_RETRY: begin
               if (retry_q == RETRY_LIM) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_ASSERT_RST;
                  if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
               end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
         endcase
      end
      if (tmr_clr || state_d != state_q) tmr_d = '0;
      else if (tmr_q == TMR_SAT)         tmr_d = tmr_q;
      else                               tmr_d = tmr_q + TW'(1);
   end

   // Decoded outputs are registered from state_d to move with state_q.
   always_ff @(posedge axi_clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tmr_q     <= '0;
         stb_q     <= '0;
         retry_q   <= '0;
         gth_rst_q <= 1'b1;
         link_up_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         stb_q     <= stb_d;
         retry_q   <= retry_d;
         gth_rst_q <= (state_d == ST_IDLE) ||
                      (state_d == ST_ASSERT_RST) ||
                      (state_d == ST_FAULT);
         link_up_q <= (state_d == ST_LINKED);
         fault_q   <= (state_d == ST_FAULT);
      end
   end

   assign state     = state_q;
   assign retry_cnt = retry_q;
   assign gth_rst   = gth_rst_q;
   assign link_up   = link_up_q;
   assign fault     = fault_q;

`ifdef GTH_LINK_CTL_STATS_EN
   logic [15:0] drop_q;
   logic [31:0] up_q, last_up_q, up_inc;

   // up_q is 0 in the first LINKED cycle, so the interval is up_q+1.
   assign up_inc = (up_q == 32'hFFFF_FFFF) ? up_q : up_q + 32'd1;

   always_ff @(posedge axi_clk) begin
      if (rst) begin
         drop_q    <= '0;
         up_q      <= '0;
         last_up_q <= '0;
      end else begin
         if (state_q == ST_LINKED && state_d == ST_RETRY &&
             drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
         if (state_q == ST_LINKED) begin
            up_q <= up_inc;
            if (state_d != ST_LINKED) last_up_q <= up_inc;
         end else begin
            up_q <= '0;
         end
      end
   end

   assign drop_cnt       = drop_q;
   assign last_up_cycles = last_up_q;
`endif

endmodule
